// File: rtl/shift_register_universal.sv
// Universal WIDTH-bit shift register: hold/shift/rotate/load/clear plus a counted multi-step engine.
// Latency: single-step and immediate commands finish at the accepting edge; k-step commands take k edges.
// Backpressure: busy=1 while a multi-step command runs; start and its operands are ignored until busy drops.
module shift_register_universal #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] shift_amt,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] out,
    output logic             ser_out_msb,
    output logic             ser_out_lsb,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_SHL  = 3'd1;
    localparam logic [2:0] MODE_SHR  = 3'd2;
    localparam logic [2:0] MODE_ROL  = 3'd3;
    localparam logic [2:0] MODE_ROR  = 3'd4;
    localparam logic [2:0] MODE_LOAD = 3'd5;
    localparam logic [2:0] MODE_CLR  = 3'd6;

    state_t           state;
    logic [2:0]       lat_mode;
    logic [CNT_W-1:0] remaining;

    // One step of a shift/rotate mode; anything else leaves the value as-is.
    function automatic logic [WIDTH-1:0] step_fn(
        input logic [2:0]       md,
        input logic [WIDTH-1:0] v,
        input logic             s
    );
        case (md)
            MODE_SHL: step_fn = {v[WIDTH-2:0], s};
            MODE_SHR: step_fn = {s, v[WIDTH-1:1]};
            MODE_ROL: step_fn = {v[WIDTH-2:0], v[WIDTH-1]};
            MODE_ROR: step_fn = {v[0], v[WIDTH-1:1]};
            default:  step_fn = v;
        endcase
    endfunction

    // Serial taps are plain wires off the register.
    assign ser_out_msb = out[WIDTH-1];
    assign ser_out_lsb = out[0];

    // Command acceptance in IDLE and step sequencing in RUN; done is a registered one-cycle pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            out       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
            lat_mode  <= MODE_HOLD;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lat_mode <= mode;
                        case (mode)
                            MODE_LOAD: begin
                                out  <= par_in;
                                done <= 1'b1;
                            end
                            MODE_CLR: begin
                                out  <= '0;
                                done <= 1'b1;
                            end
                            MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR: begin
                                if (shift_amt == '0) begin
                                    done <= 1'b1;
                                end else begin
                                    out <= step_fn(mode, out, ser_in);
                                    if (shift_amt == CNT_W'(1)) begin
                                        done <= 1'b1;
                                    end else begin
                                        // First step already applied at this edge.
                                        state     <= RUN;
                                        busy      <= 1'b1;
                                        remaining <= shift_amt - CNT_W'(1);
                                    end
                                end
                            end
                            default: begin
                                done <= 1'b1;
                            end
                        endcase
                    end
                end
                RUN: begin
                    out       <= step_fn(lat_mode, out, ser_in);
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_register_universal.sv
// Bench for shift_register_universal (WIDTH=8): directed scenarios plus random commands.
// Reference model tracks the register value and pending step count with integer arithmetic.
// Every cycle the DUT outputs are compared to the model one time unit after the rising edge.
module tb_shift_register_universal;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    mode = '0;
    logic [CW-1:0] shift_amt = '0;
    logic          ser_in = 1'b0;
    logic [W-1:0]  par_in = '0;
    logic [W-1:0]  out;
    logic          ser_out_msb;
    logic          ser_out_lsb;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_out  = 0;
    int m_rem  = 0;
    int m_mode = 0;
    bit m_done = 1'b0;

    shift_register_universal #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .shift_amt   (shift_amt),
        .ser_in      (ser_in),
        .par_in      (par_in),
        .out         (out),
        .ser_out_msb (ser_out_msb),
        .ser_out_lsb (ser_out_lsb),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One step on an 8-bit value, by arithmetic.
    function automatic int step_ref(input int md, input int v, input int s);
        case (md)
            1:       return (v * 2 + s) % 256;
            2:       return v / 2 + s * 128;
            3:       return (v * 2) % 256 + v / 128;
            4:       return v / 2 + (v % 2) * 128;
            default: return v;
        endcase
    endfunction

    task automatic model_reset();
        m_out  = 0;
        m_rem  = 0;
        m_done = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        if (!rst) begin
            model_reset();
            return;
        end
        m_done = 1'b0;
        if (m_rem > 0) begin
            m_out = step_ref(m_mode, m_out, int'(ser_in));
            m_rem--;
            if (m_rem == 0) m_done = 1'b1;
        end else if (start) begin
            m_mode = int'(mode);
            if (mode == 3'd5) begin
                m_out = int'(par_in);
                m_done = 1'b1;
            end else if (mode == 3'd6) begin
                m_out = 0;
                m_done = 1'b1;
            end else if (mode >= 3'd1 && mode <= 3'd4 && shift_amt != 0) begin
                m_out = step_ref(m_mode, m_out, int'(ser_in));
                m_rem = int'(shift_amt) - 1;
                if (m_rem == 0) m_done = 1'b1;
            end else begin
                m_done = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out"}, 32'(out), 32'(m_out));
        check({tag, ".busy"}, 32'(busy), 32'(m_rem > 0));
        check({tag, ".done"}, 32'(done), 32'(m_done));
        check({tag, ".msb"}, 32'(ser_out_msb), 32'(m_out / 128));
        check({tag, ".lsb"}, 32'(ser_out_lsb), 32'(m_out % 2));
        check({tag, ".done_busy"}, 32'(done & busy), 32'(0));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic cmd(input int md, input int amt, input logic s, input logic [W-1:0] p, input string tag);
        start     = 1'b1;
        mode      = 3'(md);
        shift_amt = CW'(amt);
        ser_in    = s;
        par_in    = p;
        tick(tag);
        start = 1'b0;
    endtask

    // Drive garbage command inputs that must be ignored while busy.
    task automatic junk();
        start     = 1'b1;
        mode      = 3'($urandom_range(0, 7));
        shift_amt = CW'($urandom_range(0, 15));
        par_in    = W'($urandom);
    endtask

    logic [7:0] sipo_bits;

    initial begin
        // Reset state before any clock edge
        #2;
        check_all("reset0");
        check("reset0.out_const", 32'(out), 32'h0);
        #6 rst = 1'b1;

        // Asynchronous reset between edges, then held across edges
        cmd(5, 0, 1'b0, 8'hA5, "load_a5");
        check("load_a5.val", 32'(out), 32'hA5);
        #3 rst = 1'b0;
        model_reset();
        #1;
        check("areset.out", 32'(out), 32'h0);
        check("areset.busy", 32'(busy), 32'h0);
        check("areset.done", 32'(done), 32'h0);
        tick("rst_hold1");
        tick("rst_hold2");
        rst = 1'b1;

        // Serial-in/parallel-out equivalence
        sipo_bits = 8'b1011_0010;
        for (int i = 0; i < 8; i++) cmd(1, 1, sipo_bits[7-i], 8'h00, "sipo");
        check("sipo.val", 32'(out), 32'hB2);

        // Multi-step rotate left with ignored inputs while busy
        cmd(5, 0, 1'b0, 8'h81, "load_81");
        cmd(3, 3, 1'b0, 8'h00, "rol3_e0");
        check("rol3.busy_e0", 32'(busy), 32'h1);
        junk();
        tick("rol3_e1");
        check("rol3.busy_e1", 32'(busy), 32'h1);
        junk();
        tick("rol3_e2");
        check("rol3.val", 32'(out), 32'h0C);
        check("rol3.done", 32'(done), 32'h1);
        start = 1'b0;
        tick("rol3_after");
        check("rol3.done_once", 32'(done), 32'h0);

        // Shift right with fill of ones then zeros
        cmd(5, 0, 1'b0, 8'hF0, "load_f0");
        cmd(2, 4, 1'b1, 8'h00, "shr4_1");
        for (int i = 0; i < 3; i++) tick("shr4_1_run");
        check("shr4_1.val", 32'(out), 32'hFF);
        cmd(5, 0, 1'b0, 8'hF0, "load_f0b");
        cmd(2, 4, 1'b0, 8'h00, "shr4_0");
        for (int i = 0; i < 3; i++) tick("shr4_0_run");
        check("shr4_0.val", 32'(out), 32'h0F);

        // Boundaries
        cmd(5, 0, 1'b0, 8'hAB, "load_ab");
        cmd(1, 0, 1'b1, 8'h00, "amt0");
        check("amt0.val", 32'(out), 32'hAB);
        check("amt0.done", 32'(done), 32'h1);
        cmd(5, 0, 1'b0, 8'hFF, "load_ff");
        cmd(1, 8, 1'b0, 8'h00, "shl8");
        for (int i = 0; i < 7; i++) tick("shl8_run");
        check("shl8.val", 32'(out), 32'h00);
        cmd(5, 0, 1'b0, 8'h5A, "load_5a");
        cmd(6, 0, 1'b1, 8'h77, "clear");
        check("clear.val", 32'(out), 32'h00);
        cmd(5, 0, 1'b0, 8'hC3, "load_c3");
        cmd(0, 5, 1'b1, 8'h11, "hold0");
        check("hold0.val", 32'(out), 32'hC3);
        cmd(7, 5, 1'b1, 8'h22, "hold7");
        check("hold7.val", 32'(out), 32'hC3);
        check("hold7.done", 32'(done), 32'h1);

        // Reset during a multi-step rotate aborts it without a done pulse
        cmd(5, 0, 1'b0, 8'h01, "load_01");
        cmd(4, 6, 1'b0, 8'h00, "ror6_e0");
        tick("ror6_e1");
        tick("ror6_e2");
        #3 rst = 1'b0;
        model_reset();
        #1;
        check("abort.out", 32'(out), 32'h0);
        check("abort.busy", 32'(busy), 32'h0);
        check("abort.done", 32'(done), 32'h0);
        tick("abort_hold");
        rst = 1'b1;
        cmd(5, 0, 1'b0, 8'h3C, "load_3c");
        check("post_abort.val", 32'(out), 32'h3C);
        check("post_abort.done", 32'(done), 32'h1);

        // Random commands, including garbage while busy and over-width counts
        for (int i = 0; i < 600; i++) begin
            start     = 1'($urandom_range(0, 1));
            mode      = 3'($urandom_range(0, 7));
            shift_amt = CW'($urandom_range(0, 10));
            ser_in    = 1'($urandom_range(0, 1));
            par_in    = W'($urandom);
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_register_universal.md
# shift_register_universal

Parametrised universal shift register: a WIDTH-bit register with serial input, hold, logical shift, rotate, parallel load and clear, plus a counted multi-step shift engine with a busy/done handshake. It succeeds the fixed 8-bit serial-in/parallel-out shift register as the general shifting primitive for serialisers, deserialisers and barrel-style sequencing in the datapath. A WIDTH=8 instance issuing single-step shift-left commands every cycle reproduces the old 8-bit SIPO behaviour.

## Interface

Parameters:
- WIDTH, 8, register width in bits (≥ 2)
- CNT_W, $clog2(WIDTH+1) (localparam), width of the step count

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  command strobe; accepted only while busy=0
- mode  input  3  operation: 0 hold, 1 shift left, 2 shift right, 3 rotate left, 4 rotate right, 5 parallel load, 6 clear, 7 hold
- shift_amt  input  CNT_W  number of steps for modes 1–4
- ser_in  input  1  serial input bit
- par_in  input  WIDTH  parallel load data
- out  output  WIDTH  register contents
- ser_out_msb  output  1  out[WIDTH-1]
- ser_out_lsb  output  1  out[0]
- busy  output  1  multi-step command in progress
- done  output  1  one-cycle pulse: command completed

## Operation

- Two states: IDLE, RUN. Reset → IDLE.
- Step definitions:
  - shift left: out ← {out[WIDTH-2:0], ser_in}
  - shift right: out ← {ser_in, out[WIDTH-1:1]}
  - rotate left: out ← {out[WIDTH-2:0], out[WIDTH-1]}
  - rotate right: out ← {out[0], out[WIDTH-1:1]}
- IDLE, start=1 at edge E0: mode and shift_amt are latched.
  - Modes 0, 7: out unchanged; done=1 after E0.
  - Mode 5: out ← par_in at E0; done=1 after E0.
  - Mode 6: out ← 0 at E0; done=1 after E0.
  - Modes 1–4 with shift_amt=0: out unchanged; done=1 after E0.
  - Modes 1–4 with shift_amt=1: one step at E0; done=1 after E0; stays IDLE.
  - Modes 1–4 with shift_amt=k>1: step at E0; go to RUN with remaining=k-1.
- RUN: one step per edge using the latched mode. ser_in is sampled live at every step edge. On the edge applying the final step: → IDLE, busy=0 and done=1 after that edge.
- start, mode, shift_amt and par_in are ignored while busy=1. No queueing.
- In IDLE with start=0, out holds.
- shift_amt values above WIDTH are executed literally; there is no saturation or modulo.
- ser_out_msb and ser_out_lsb are combinational taps of out.

## Timing

- Reset (rst=0, asynchronous): out=0, busy=0, done=0, remaining=0, state=IDLE, immediately and independent of clk.
- Reset release is synchronous to the next rising edge; the first command can be accepted at that edge.
- Reset asserted mid-RUN aborts the command. No done pulse is issued for it.
- Latency: a k-step command (k≥1) completes in k cycles, with done high in the cycle after the last step edge.
  - busy is high after edges E0..E(k-2) and low after E(k-1).
  - Single-cycle commands never raise busy.
- Throughput: a new command may start in the same cycle done is high. Back-to-back single-step shifts give 1 bit/cycle.
- done is exactly one cycle wide and never coincides with busy=1.

## Test plan

- Reset: drive out non-zero via load 0xA5, assert rst=0 between clock edges → out=0x00, busy=0, done=0 immediately. Hold rst low across edges → no change.
- SIPO equivalence, WIDTH=8: start=1 every cycle, mode=1, shift_amt=1, ser_in=1,0,1,1,0,0,1,0 → out=0xB2 after 8 edges. done high each cycle, busy never high.
- Multi-step rotate: load 0x81, then mode=3, shift_amt=3 → busy high for 2 cycles, out=0x0C, single done pulse after the 3rd edge. Toggling start/mode during busy has no effect.
- Shift right with fill: load 0xF0, then mode=2, shift_amt=4, ser_in held 1 → out=0xFF. Repeat with ser_in=0 → 0x0F. Check ser_out_lsb tracks out[0] each cycle.
- Boundaries: shift_amt=0 in mode 1 → out unchanged, done after 1 cycle, busy low. shift_amt=8 in mode 1 with ser_in=0 on 0xFF → 0x00 after 8 steps. Mode 6 → 0x00 in 1 cycle. Modes 0/7 → unchanged with a done pulse.
- Abort: start mode=4, shift_amt=6 on 0x01, assert rst after 3 edges → out=0, busy=0, no done. After release, load 0x3C → out=0x3C, done pulse.
